// File: rtl/limbus_st_width_downsizer.sv
// -----------------------------------------------------------------------------
// limbus_st_width_downsizer
//
// Avalon-ST data format adapter. Each wide input beat of IN_SYMBOLS symbols is
// held in a one-beat holding register. It is then emitted as up to
// RATIO = IN_SYMBOLS/OUT_SYMBOLS narrow output beats. On a short eop beat the
// unused trailing slices are dropped, so the narrow side never carries padding.
// Packet framing (sop/eop/empty), error and channel travel with the data.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_*                  : wide Avalon-ST sink (ready/valid/data/sop/eop/
//                           empty/error/channel)
//   out_*                 : narrow Avalon-ST source, fully registered outputs
//
// Symbol order: MSB_FIRST=1 puts symbol 0 in the data MSBs on both sides.
// MSB_FIRST=0 puts symbol 0 in the LSBs.
// -----------------------------------------------------------------------------
module limbus_st_width_downsizer #(
    parameter int SYMBOL_W    = 8,
    parameter int IN_SYMBOLS  = 4,
    parameter int OUT_SYMBOLS = 2,
    parameter int CHANNEL_W   = 1,
    parameter int MSB_FIRST   = 1,
    localparam int RATIO       = IN_SYMBOLS / OUT_SYMBOLS,
    localparam int IN_EMPTY_W  = ($clog2(IN_SYMBOLS) > 1) ? $clog2(IN_SYMBOLS) : 1,
    localparam int OUT_EMPTY_W = ($clog2(OUT_SYMBOLS) > 1) ? $clog2(OUT_SYMBOLS) : 1,
    localparam int CNT_W       = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            in_ready,
    input  logic                            in_valid,
    input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  in_data,
    input  logic                            in_startofpacket,
    input  logic                            in_endofpacket,
    input  logic [IN_EMPTY_W-1:0]           in_empty,
    input  logic                            in_error,
    input  logic [CHANNEL_W-1:0]            in_channel,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    output logic [OUT_EMPTY_W-1:0]          out_empty,
    output logic                            out_error,
    output logic [CHANNEL_W-1:0]            out_channel
);

    localparam int IN_W  = IN_SYMBOLS * SYMBOL_W;
    localparam int OUT_W = OUT_SYMBOLS * SYMBOL_W;

    // Largest legal empty value; wider compare so an out-of-range value is seen.
    localparam logic [IN_EMPTY_W:0] EMPTY_MAX = (IN_EMPTY_W + 1)'(IN_SYMBOLS - 1);

    // Reject symbol ratios the slicing logic cannot represent.
    generate
        if ((OUT_SYMBOLS < 1) || ((IN_SYMBOLS % OUT_SYMBOLS) != 0) ||
            ((IN_SYMBOLS / OUT_SYMBOLS) < 2)) begin : g_bad_params
            $error("limbus_st_width_downsizer: IN_SYMBOLS must be a multiple of OUT_SYMBOLS with ratio >= 2");
        end
    endgenerate

    // Holding register
    logic                  a_valid_q, a_valid_d;
    logic [IN_W-1:0]       a_data_q, a_data_d;
    logic                  a_sop_q, a_sop_d;
    logic                  a_eop_q, a_eop_d;
    logic [IN_EMPTY_W-1:0] a_empty_q, a_empty_d;
    logic                  a_error_q, a_error_d;
    logic [CHANNEL_W-1:0]  a_channel_q, a_channel_d;

    // Slice counter
    logic [CNT_W-1:0]      idx_q, idx_d;

    // Output register
    logic                   out_valid_q, out_valid_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [OUT_EMPTY_W-1:0] out_empty_q, out_empty_d;
    logic                   out_error_q, out_error_d;
    logic [CHANNEL_W-1:0]   out_channel_q, out_channel_d;

    // Combinational helpers
    logic                   adv_s;
    logic                   last_hit_s;
    logic                   in_ready_s;
    logic                   load_s;
    logic                   release_s;
    logic [CNT_W-1:0]       last_s;
    logic [OUT_EMPTY_W-1:0] eop_empty_s;
    logic [IN_EMPTY_W-1:0]  in_empty_clamped_s;
    logic [OUT_W-1:0]       slice_sel_s;
    logic [OUT_W-1:0]       slice_s [RATIO];

    // Slice k holds symbols k*OUT_SYMBOLS.. in the same order within out_data.
    // With MSB-first packing slice 0 is the top OUT_W bits of the input word.
    generate
        for (genvar k = 0; k < RATIO; k++) begin : g_slice
            if (MSB_FIRST != 0) begin : g_msb
                assign slice_s[k] = a_data_q[(RATIO-1-k)*OUT_W +: OUT_W];
            end else begin : g_lsb
                assign slice_s[k] = a_data_q[k*OUT_W +: OUT_W];
            end
        end
    endgenerate

    // Pick the slice addressed by idx.
    always_comb begin
        slice_sel_s = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx_q == CNT_W'(k)) begin
                slice_sel_s = slice_s[k];
            end else begin
                slice_sel_s = slice_sel_s;
            end
        end
    end

    // Empty is meaningful only on eop. Clamp illegal values so at least one
    // symbol survives.
    always_comb begin
        if (!in_endofpacket) begin
            in_empty_clamped_s = '0;
        end else if ({1'b0, in_empty} > EMPTY_MAX) begin
            in_empty_clamped_s = EMPTY_MAX[IN_EMPTY_W-1:0];
        end else begin
            in_empty_clamped_s = in_empty;
        end
    end

    // Last slice index and the narrow-side empty for the held beat.
    // With N valid symbols: L = ceil(N/OUT)-1 and empty = (L+1)*OUT - N.
    always_comb begin
        int n_i;
        int last_i;
        n_i         = IN_SYMBOLS - int'(a_empty_q);
        last_i      = (n_i - 1) / OUT_SYMBOLS;
        last_s      = CNT_W'(RATIO - 1);
        eop_empty_s = '0;
        if (a_eop_q) begin
            last_s      = CNT_W'(last_i);
            eop_empty_s = OUT_EMPTY_W'((last_i + 1) * OUT_SYMBOLS - n_i);
        end else begin
            last_s      = CNT_W'(RATIO - 1);
            eop_empty_s = '0;
        end
    end

    // Handshake decode. A new beat may load in the same cycle the last slice
    // of the current beat leaves, so the narrow side never bubbles.
    always_comb begin
        adv_s      = out_ready || !out_valid_q;
        last_hit_s = (idx_q == last_s);
        in_ready_s = !reset && (!a_valid_q || (adv_s && last_hit_s));
        load_s     = in_valid && in_ready_s;
        release_s  = adv_s && a_valid_q && last_hit_s;
    end

    // Next-state for the holding register and the slice counter.
    always_comb begin
        a_valid_d   = a_valid_q;
        a_data_d    = a_data_q;
        a_sop_d     = a_sop_q;
        a_eop_d     = a_eop_q;
        a_empty_d   = a_empty_q;
        a_error_d   = a_error_q;
        a_channel_d = a_channel_q;
        idx_d       = idx_q;
        if (load_s) begin
            a_valid_d   = 1'b1;
            a_data_d    = in_data;
            a_sop_d     = in_startofpacket;
            a_eop_d     = in_endofpacket;
            a_empty_d   = in_empty_clamped_s;
            a_error_d   = in_error;
            a_channel_d = in_channel;
        end else if (release_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
        if (adv_s && a_valid_q) begin
            if (last_hit_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Next-state for the output register. It holds while the sink stalls.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_empty_d   = out_empty_q;
        out_error_d   = out_error_q;
        out_channel_d = out_channel_q;
        if (adv_s) begin
            if (a_valid_q) begin
                out_valid_d   = 1'b1;
                out_data_d    = slice_sel_s;
                out_sop_d     = a_sop_q && (idx_q == '0);
                out_eop_d     = a_eop_q && last_hit_s;
                out_empty_d   = (a_eop_q && last_hit_s) ? eop_empty_s : '0;
                out_error_d   = a_error_q;
                out_channel_d = a_channel_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers. Reset drops any held or in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q     <= 1'b0;
            a_data_q      <= '0;
            a_sop_q       <= 1'b0;
            a_eop_q       <= 1'b0;
            a_empty_q     <= '0;
            a_error_q     <= 1'b0;
            a_channel_q   <= '0;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_empty_q   <= '0;
            out_error_q   <= 1'b0;
            out_channel_q <= '0;
        end else begin
            a_valid_q     <= a_valid_d;
            a_data_q      <= a_data_d;
            a_sop_q       <= a_sop_d;
            a_eop_q       <= a_eop_d;
            a_empty_q     <= a_empty_d;
            a_error_q     <= a_error_d;
            a_channel_q   <= a_channel_d;
            idx_q         <= idx_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_empty_q   <= out_empty_d;
            out_error_q   <= out_error_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign in_ready          = in_ready_s;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_empty         = out_empty_q;
    assign out_error         = out_error_q;
    assign out_channel       = out_channel_q;

endmodule
